// File: rtl/br_flow_demux_credit_scheduler.sv
// br_flow_demux_credit_scheduler: credit-tracked round-robin demux of one push stream to NumRequesters destinations.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push_*         upstream ready-valid stream (push_ready depends on registered credits only)
//   pop_valid      registered one-hot0 destination strobe, no backpressure
//   pop_data       registered payload replicated to every destination slot
//   credit_return  per-destination credit return pulses
//   credit_count   current credits per destination
//   last_select    destination of the most recent transfer
module br_flow_demux_credit_scheduler #(
    parameter int NumRequesters = 2,
    parameter int BitWidth = 1,
    parameter int MaxCredits = 4,
    parameter bit EnableIntegAsserts = 1'b1,
    localparam int CW = $clog2(MaxCredits + 1),
    localparam int SW = $clog2(NumRequesters)
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    output logic                                    push_ready,
    input  logic                                    push_valid,
    input  logic [BitWidth-1:0]                     push_data,
    output logic [NumRequesters-1:0]                pop_valid,
    output logic [NumRequesters-1:0][BitWidth-1:0]  pop_data,
    input  logic [NumRequesters-1:0]                credit_return,
    output logic [NumRequesters-1:0][CW-1:0]        credit_count,
    output logic [SW-1:0]                           last_select
);
    logic [NumRequesters-1:0] eligible;
    logic [NumRequesters-1:0] grant;
    logic [SW-1:0]            rr_ptr;
    logic [SW-1:0]            grant_idx;
    logic                     xfer;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NumRequesters; i++) eligible[i] = credit_count[i] != '0;
    end

    // Scan downward so the closest eligible destination at/after rr_ptr wins last.
    always_comb begin
        grant_idx = rr_ptr;
        for (int k = NumRequesters - 1; k >= 0; k--)
            if (eligible[(int'(rr_ptr) + k) % NumRequesters])
                grant_idx = SW'((int'(rr_ptr) + k) % NumRequesters);
    end

    assign push_ready = |eligible;
    assign xfer       = push_valid && push_ready;
    assign grant      = xfer ? {{(NumRequesters-1){1'b0}}, 1'b1} << grant_idx : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_valid    <= '0;
            pop_data     <= '0;
            rr_ptr       <= '0;
            last_select  <= '0;
            credit_count <= {NumRequesters{CW'(MaxCredits)}};
        end else begin
            pop_valid <= grant;
            if (xfer) begin
                pop_data    <= {NumRequesters{push_data}};
                rr_ptr      <= grant_idx == SW'(NumRequesters - 1) ? '0 : grant_idx + 1'b1;
                last_select <= grant_idx;
            end
            // A return at full count saturates rather than wrapping.
            for (int i = 0; i < NumRequesters; i++)
                if (grant[i] && !credit_return[i])
                    credit_count[i] <= credit_count[i] - 1'b1;
                else if (credit_return[i] && !grant[i] && credit_count[i] != CW'(MaxCredits))
                    credit_count[i] <= credit_count[i] + 1'b1;
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(pop_valid));

    for (genvar i = 0; i < NumRequesters; i++) begin : g_chk
        a_grant_credit: assert property (@(posedge clk) disable iff (!rst_n) grant[i] |-> eligible[i]);
        if (EnableIntegAsserts) begin : g_integ
            a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                credit_return[i] |-> credit_count[i] != CW'(MaxCredits));
        end
    end

    if (EnableIntegAsserts) begin : g_hold
        a_push_hold: assert property (@(posedge clk) disable iff (!rst_n)
            push_valid && !push_ready |=> push_valid && $stable(push_data));
    end
endmodule

// File: tb/tb_br_flow_demux_credit_scheduler.sv
// tb_br_flow_demux_credit_scheduler: directed checks of credits, round-robin grant, output register and async reset.
module tb_br_flow_demux_credit_scheduler;
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            push_ready;
    logic            push_valid = 1'b0;
    logic [3:0]      push_data = '0;
    logic [2:0]      pop_valid;
    logic [2:0][3:0] pop_data;
    logic [2:0]      credit_return = '0;
    logic [2:0][1:0] credit_count;
    logic [1:0]      last_select;
    int              errors = 0;
    int              checks = 0;

    br_flow_demux_credit_scheduler #(
        .NumRequesters(3),
        .BitWidth(4),
        .MaxCredits(2),
        .EnableIntegAsserts(1'b0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .push_ready(push_ready),
        .push_valid(push_valid),
        .push_data(push_data),
        .pop_valid(pop_valid),
        .pop_data(pop_data),
        .credit_return(credit_return),
        .credit_count(credit_count),
        .last_select(last_select)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        check("rst_pop_valid", 32'(pop_valid), 0);
        check("rst_pop_data", 32'(pop_data), 0);
        check("rst_credits", 32'(credit_count), 32'b10_10_10);
        check("rst_last_select", 32'(last_select), 0);
        check("rst_push_ready", 32'(push_ready), 1);
        rst_n = 1'b1;
        // Continuous push, no returns: strict rotation until credits run out.
        push_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            push_data = 4'(k + 1);
            cyc();
            check("rot_pop_valid", 32'(pop_valid), 32'(3'b001 << (k % 3)));
            check("rot_pop_data", 32'(pop_data), 32'({3{4'(k + 1)}}));
        end
        check("drain_push_ready", 32'(push_ready), 0);
        check("drain_credits", 32'(credit_count), 0);
        push_valid = 1'b0;
        cyc();
        check("idle_pop_valid", 32'(pop_valid), 0);
        check("idle_pop_data_hold", 32'(pop_data), 32'({3{4'd6}}));
        // Destination 1 starved: skipped from rr_ptr=1, pointer wraps to 0.
        credit_return = 3'b101;
        cyc();
        cyc();
        check("refill_credits", 32'(credit_count), 32'b10_00_10);
        credit_return = '0;
        push_valid = 1'b1;
        push_data = 4'd5;
        cyc();
        check("skip_pre_pop", 32'(pop_valid), 32'b001);
        push_data = 4'd6;
        cyc();
        check("skip_pop", 32'(pop_valid), 32'b100);
        check("skip_last_select", 32'(last_select), 2);
        push_data = 4'd7;
        cyc();
        check("wrap_pop", 32'(pop_valid), 32'b001);
        check("wrap_credits", 32'(credit_count), 32'b01_00_00);
        // Simultaneous grant and return on destination 0.
        push_data = 4'd8;
        cyc();
        check("empty_pop", 32'(pop_valid), 32'b100);
        push_valid = 1'b0;
        credit_return = 3'b001;
        cyc();
        check("ret0_count", 32'(credit_count[0]), 1);
        push_valid = 1'b1;
        push_data = 4'd9;
        cyc();
        check("simul_count", 32'(credit_count[0]), 1);
        check("simul_pop", 32'(pop_valid), 32'b001);
        check("simul_data", 32'(pop_data), 32'({3{4'd9}}));
        credit_return = '0;
        // Exhaust, hold 0xA, then a credit for destination 2 releases it.
        push_data = 4'd3;
        cyc();
        check("exh_pop", 32'(pop_valid), 32'b001);
        push_data = 4'hA;
        cyc();
        check("stall_push_ready", 32'(push_ready), 0);
        check("stall_pop", 32'(pop_valid), 0);
        cyc();
        check("stall_pop2", 32'(pop_valid), 0);
        credit_return = 3'b100;
        cyc();
        check("ret2_push_ready", 32'(push_ready), 1);
        check("ret2_pop", 32'(pop_valid), 0);
        check("ret2_count", 32'(credit_count[2]), 1);
        credit_return = '0;
        cyc();
        check("ret2_xfer_pop", 32'(pop_valid), 32'b100);
        check("ret2_xfer_data", 32'(pop_data), 32'({3{4'hA}}));
        check("ret2_last_select", 32'(last_select), 2);
        check("ret2_push_ready_low", 32'(push_ready), 0);
        push_valid = 1'b0;
        // Return beyond MaxCredits saturates.
        credit_return = 3'b001;
        cyc();
        cyc();
        check("fill0_count", 32'(credit_count[0]), 2);
        cyc();
        check("sat0_count", 32'(credit_count[0]), 2);
        credit_return = '0;
        // Asynchronous reset while pop_valid=010.
        credit_return = 3'b010;
        cyc();
        credit_return = '0;
        push_valid = 1'b1;
        push_data = 4'd4;
        cyc();
        check("pre_rst_pop0", 32'(pop_valid), 32'b001);
        push_data = 4'd5;
        cyc();
        check("pre_rst_pop1", 32'(pop_valid), 32'b010);
        push_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_pop_valid", 32'(pop_valid), 0);
        check("arst_pop_data", 32'(pop_data), 0);
        check("arst_credits", 32'(credit_count), 32'b10_10_10);
        check("arst_last_select", 32'(last_select), 0);
        check("arst_push_ready", 32'(push_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        push_valid = 1'b1;
        push_data = 4'd7;
        cyc();
        check("post_rst_pop", 32'(pop_valid), 32'b001);
        push_valid = 1'b0;
        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
